// File: rtl/inst_encoder_if.sv
// Request/response bundle for inst_encoder: decoded instruction fields in,
// encoded RV32 words out, each side with a valid/ready handshake.
interface inst_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fmt;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        resp_last;

    modport master (
        output req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
               req_rd, req_rs1, req_rs2, req_imm, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_err, resp_last
    );

    modport slave (
        input  req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
               req_rd, req_rs1, req_rs2, req_imm, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_err, resp_last
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs fields and immediates into 32-bit words.
// Define INST_ENCODER_LI_EXPAND_EN to expand the LI pseudo into LUI/ADDI.
module inst_encoder (
    input  logic          clk,
    input  logic          reset,
    inst_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_OUT_FIRST = 2'd1,
        ST_OUT_LAST  = 2'd2
    } state_t;

    typedef struct packed {
        logic        err;
        logic        two;
        logic [31:0] first;
        logic [31:0] second;
    } enc_t;

    function automatic enc_t encode(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        enc_t e;
`ifdef INST_ENCODER_LI_EXPAND_EN
        logic [31:0] sum;
`endif
        e = '0;
        case (fmt)
            3'd0: e.first = {f7, rs2, rs1, f3, rd, op};
            3'd1: begin
                e.first = {imm[11:0], rs1, f3, rd, op};
                e.err   = (imm[31:11] != {21{imm[11]}});
            end
            3'd2: begin
                e.first = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                e.err   = (imm[31:11] != {21{imm[11]}});
            end
            3'd3: begin
                e.first = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                e.err   = (imm[31:12] != {20{imm[12]}}) || imm[0];
            end
            3'd4: begin
                e.first = {imm[31:12], rd, op};
                e.err   = (imm[11:0] != 12'd0);
            end
            3'd5: begin
                e.first = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                e.err   = (imm[31:20] != {12{imm[20]}}) || imm[0];
            end
            3'd6: begin
                e.first = {imm[31:20], imm[4:0], f3, rd, op};
                e.err   = (imm[19:5] != 15'd0);
            end
            3'd7: begin
`ifdef INST_ENCODER_LI_EXPAND_EN
                // Rounding by 0x800 compensates for ADDI sign-extending lo.
                sum = imm + 32'h0000_0800;
                if (imm[31:11] == {21{imm[11]}}) begin
                    e.first = {imm[11:0], 5'd0, 3'd0, rd, 7'h13};
                end else begin
                    e.first  = {sum[31:12], rd, 7'h37};
                    e.second = {imm[11:0], rd, 3'd0, rd, 7'h13};
                    e.two    = (imm[11:0] != 12'd0);
                end
`else
                e.first = 32'd0;
                e.err   = 1'b1;
`endif
            end
            default: begin
                e.first = 32'd0;
                e.err   = 1'b1;
            end
        endcase
        return e;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic [31:0] inst_r, inst_nxt_s;
    logic        err_r, err_nxt_s;
    logic        last_r, last_nxt_s;
    logic [31:0] pend_r, pend_nxt_s;
    logic        ready_s;
    logic        load_s;
    enc_t        enc_s;

    // Request acceptance depends on the output slot being free or draining.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE:      ready_s = 1'b1;
            ST_OUT_LAST:  ready_s = bus.resp_ready;
            ST_OUT_FIRST: ready_s = 1'b0;
            default:      ready_s = 1'b0;
        endcase
    end

    // Next-state and next-output computation.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = valid_r;
        inst_nxt_s  = inst_r;
        err_nxt_s   = err_r;
        last_nxt_s  = last_r;
        pend_nxt_s  = pend_r;
        load_s      = bus.req_valid && ready_s;
        enc_s = encode(bus.req_fmt, bus.req_opcode, bus.req_funct3, bus.req_funct7,
                       bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm);
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_OUT_FIRST: begin
                if (bus.resp_ready) begin
                    state_nxt_s = ST_OUT_LAST;
                    inst_nxt_s  = pend_r;
                    err_nxt_s   = 1'b0;
                    last_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_OUT_FIRST;
                end
            end
            ST_OUT_LAST: begin
                if (bus.resp_ready) begin
                    state_nxt_s = ST_IDLE;
                    valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_OUT_LAST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
            end
        endcase
        if (load_s) begin
            state_nxt_s = enc_s.two ? ST_OUT_FIRST : ST_OUT_LAST;
            valid_nxt_s = 1'b1;
            inst_nxt_s  = enc_s.first;
            err_nxt_s   = enc_s.err;
            last_nxt_s  = ~enc_s.two;
            pend_nxt_s  = enc_s.second;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
    end

    // State and output registers; reset drops any pending second word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            inst_r  <= 32'd0;
            err_r   <= 1'b0;
            last_r  <= 1'b0;
            pend_r  <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= valid_nxt_s;
            inst_r  <= inst_nxt_s;
            err_r   <= err_nxt_s;
            last_r  <= last_nxt_s;
            pend_r  <= pend_nxt_s;
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.resp_valid = valid_r;
    assign bus.resp_inst  = inst_r;
    assign bus.resp_err   = err_r;
    assign bus.resp_last  = last_r;
endmodule
